// File: rtl/matrix_mac_engine.sv
// NxN unsigned matrix engine: byte-serial load of A/B, MUL (one MAC per cycle) or ADD into C,
// then C streamed out LSB byte first on uo_out.
module matrix_mac_engine #(
  parameter int N  = 2,
  parameter int DW = 8,
  localparam int AW = 2*DW + $clog2(N),
  localparam int OB = (AW+7)/8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio,
  output logic [7:0] uo_out,
  output logic       uo_valid,
  output logic       busy
);

  localparam int NN = N*N;
  localparam int EW = $clog2(NN);
  localparam int CW = $clog2(N);
  localparam int BW = (OB > 1) ? $clog2(OB) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_ADD    = 3'd4;
  localparam logic [2:0] S_READ   = 3'd5;

  localparam logic [7:0] OP_LOAD_A = 8'hCA;
  localparam logic [7:0] OP_LOAD_B = 8'hCB;
  localparam logic [7:0] OP_MUL    = 8'hBB;
  localparam logic [7:0] OP_ADD    = 8'hBC;
  localparam logic [7:0] OP_READ   = 8'hEE;

  localparam logic [EW-1:0] LAST_E = EW'(NN-1);
  localparam logic [EW-1:0] N_E    = EW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N-1);
  localparam logic [BW-1:0] LAST_B = BW'(OB-1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    uio_q, uio_d;
  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] a_d [NN];
  logic [DW-1:0] b_q [NN];
  logic [DW-1:0] b_d [NN];
  logic [AW-1:0] c_q [NN];
  logic [AW-1:0] c_d [NN];
  logic [EW-1:0] idx_q, idx_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [BW-1:0] rb_q, rb_d;
  logic [7:0]    uo_q, uo_d;
  logic          valid_q, valid_d;

  logic [EW-1:0]   a_idx, b_idx, c_idx;
  logic [AW-1:0]   acc_base, mac;
  logic            rd_last;
  logic [EW-1:0]   ne, rd_e;
  logic [BW-1:0]   nb, rd_b;
  logic [OB*8-1:0] rd_ext;
  logic [7:0]      rd_byte;

  always_comb begin
    a_idx    = EW'(i_q) * N_E + EW'(k_q);
    b_idx    = EW'(k_q) * N_E + EW'(j_q);
    c_idx    = EW'(i_q) * N_E + EW'(j_q);
    acc_base = (k_q == '0) ? {AW{1'b0}} : acc_q;
    mac      = acc_base + AW'(a_q[a_idx]) * AW'(b_q[b_idx]);

    // Next byte pointer while streaming; on the READ accept edge the stream starts at (0,0).
    rd_last = (idx_q == LAST_E) && (rb_q == LAST_B);
    nb      = (rb_q == LAST_B) ? '0 : rb_q + 1'b1;
    ne      = (rb_q == LAST_B) ? idx_q + 1'b1 : idx_q;
    rd_e    = (state_q == S_READ) ? ne : '0;
    rd_b    = (state_q == S_READ) ? nb : '0;
    rd_ext  = '0;
    rd_ext[AW-1:0] = c_q[rd_e];
    rd_byte = rd_ext[8*rd_b +: 8];
  end

  always_comb begin
    state_d = state_q;
    uio_d   = uio;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    rb_d    = rb_q;
    uo_d    = 8'h00;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Edge-detected opcode: a level held across a busy period is never replayed.
        if (uio != uio_q) begin
          case (uio)
            OP_LOAD_A: begin state_d = S_LOAD_A; idx_d = '0; end
            OP_LOAD_B: begin state_d = S_LOAD_B; idx_d = '0; end
            OP_MUL:    begin state_d = S_MUL; i_d = '0; j_d = '0; k_d = '0; end
            OP_ADD:    begin state_d = S_ADD; idx_d = '0; end
            OP_READ: begin
              state_d = S_READ;
              idx_d   = '0;
              rb_d    = '0;
              uo_d    = rd_byte;
              valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (state_q == S_LOAD_A) a_d[idx_q] = ui_in[DW-1:0];
        else                     b_d[idx_q] = ui_in[DW-1:0];
        if (idx_q == LAST_E) state_d = S_IDLE;
        else                 idx_d = idx_q + 1'b1;
      end
      S_MUL: begin
        acc_d = mac;
        if (k_q == LAST_C) begin
          c_d[c_idx] = mac;
          k_d = '0;
          if (j_q == LAST_C) begin
            j_d = '0;
            if (i_q == LAST_C) state_d = S_IDLE;
            else               i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_ADD: begin
        c_d[idx_q] = AW'(a_q[idx_q]) + AW'(b_q[idx_q]);
        if (idx_q == LAST_E) state_d = S_IDLE;
        else                 idx_d = idx_q + 1'b1;
      end
      S_READ: begin
        if (rd_last) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = ne;
          rb_d    = nb;
          uo_d    = rd_byte;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      uio_q   <= '0;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      rb_q    <= '0;
      uo_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      uio_q   <= uio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      rb_q    <= rb_d;
      uo_q    <= uo_d;
      valid_q <= valid_d;
    end
  end

  assign uo_out   = uo_q;
  assign uo_valid = valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine: an N=2/DW=8 instance and an N=3/DW=4 instance
// share clock and reset; expected READ bytes come from a software matrix model.
module tb_matrix_mac_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in2, uio2, uo2, ui_in3, uio3, uo3;
  logic       v2, busy2, v3, busy3;

  int vectors = 0;
  int miscompares = 0;
  int exp2[$];
  int exp3[$];
  int vcnt[2];
  int ma[2][16];
  int mb[2][16];
  int mc[2][16];

  always #5 clk = ~clk;

  matrix_mac_engine #(.N(2), .DW(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in2), .uio(uio2),
    .uo_out(uo2), .uo_valid(v2), .busy(busy2)
  );

  matrix_mac_engine #(.N(3), .DW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in3), .uio(uio3),
    .uo_out(uo3), .uo_valid(v3), .busy(busy3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every valid byte is popped and compared.
  always @(negedge clk) begin
    if (v2) begin
      vcnt[0]++;
      if (exp2.size() == 0) check("rd2_extra", int'(v2), 0);
      else check("rd2_byte", int'(uo2), exp2.pop_front());
    end
    if (v3) begin
      vcnt[1]++;
      if (exp3.size() == 0) check("rd3_extra", int'(v3), 0);
      else check("rd3_byte", int'(uo3), exp3.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int nof(input int s);
    return (s != 0) ? 3 : 2;
  endfunction

  function automatic int obf(input int s);
    return (s != 0) ? 2 : 3;
  endfunction

  function automatic logic busy_of(input int s);
    return (s != 0) ? busy3 : busy2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uio(input int s, input logic [7:0] v);
    if (s != 0) uio3 = v;
    else        uio2 = v;
  endtask

  task automatic do_load(input int s, input logic [7:0] op, input int vals[16]);
    int n = nof(s);
    int msk = (s != 0) ? 15 : 255;
    $display("op inst%0d load %s", s, (op == 8'hCA) ? "A" : "B");
    drive_uio(s, op);
    tick();
    drive_uio(s, 8'h00);
    for (int e = 0; e < n*n; e++) begin
      if (s != 0) ui_in3 = 8'(vals[e]);
      else        ui_in2 = 8'(vals[e]);
      if (op == 8'hCA) ma[s][e] = vals[e] & msk;
      else             mb[s][e] = vals[e] & msk;
      tick();
    end
    check("load_done_idle", int'(busy_of(s)), 0);
  endtask

  task automatic do_op(input int s, input logic [7:0] op, input int glitch);
    int n = nof(s);
    int cnt = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int acc = 0;
        if (op == 8'hBB)
          for (int k = 0; k < n; k++) acc += ma[s][i*n+k] * mb[s][k*n+j];
        else
          acc = ma[s][i*n+j] + mb[s][i*n+j];
        mc[s][i*n+j] = acc;
      end
    drive_uio(s, op);
    tick();
    drive_uio(s, 8'h00);
    while (busy_of(s) && cnt < 200) begin
      cnt++;
      if (cnt == glitch) drive_uio(s, 8'hCA);
      tick();
    end
    $display("op inst%0d %s busy %0d cycles", s, (op == 8'hBB) ? "mul" : "add", cnt);
    check((op == 8'hBB) ? "mul_busy_cycles" : "add_busy_cycles", cnt, (op == 8'hBB) ? n*n*n : n*n);
  endtask

  task automatic push_expected(input int s);
    int n = nof(s);
    for (int e = 0; e < n*n; e++)
      for (int b = 0; b < obf(s); b++) begin
        if (s != 0) exp3.push_back((mc[s][e] >> (8*b)) & 255);
        else        exp2.push_back((mc[s][e] >> (8*b)) & 255);
      end
  endtask

  // Called with the READ accept edge just passed.
  task automatic read_wait(input int s);
    int n = nof(s);
    int cnt = 0;
    while (busy_of(s) && cnt < 200) begin
      cnt++;
      tick();
    end
    $display("op inst%0d read %0d bytes", s, vcnt[s]);
    check("read_busy_cycles", cnt, n*n*obf(s));
    check("read_valid_cycles", vcnt[s], n*n*obf(s));
    check("read_uo_after", int'((s != 0) ? uo3 : uo2), 0);
    check("read_valid_after", int'((s != 0) ? v3 : v2), 0);
    check("scoreboard_drained", (s != 0) ? exp3.size() : exp2.size(), 0);
  endtask

  task automatic do_read(input int s);
    push_expected(s);
    vcnt[s] = 0;
    drive_uio(s, 8'hEE);
    tick();
    drive_uio(s, 8'h00);
    read_wait(s);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 16; e++) begin
        ma[s][e] = 0;
        mb[s][e] = 0;
        mc[s][e] = 0;
      end
  endtask

  initial begin
    int va[16];
    int vb[16];
    rst_n = 1'b0;
    uio2 = 8'h00; ui_in2 = 8'h00;
    uio3 = 8'h00; ui_in3 = 8'h00;
    clear_model();
    tick();
    tick();
    check("reset_busy", int'(busy2), 0);
    check("reset_uo", int'(uo2), 0);
    check("reset_valid", int'(v2), 0);
    check("reset_busy3", int'(busy3), 0);
    rst_n = 1'b1;
    tick();

    // 1: small product
    for (int e = 0; e < 16; e++) begin va[e] = e + 1; vb[e] = e + 5; end
    do_load(0, 8'hCA, va);
    do_load(0, 8'hCB, vb);
    do_op(0, 8'hBB, 0);
    do_read(0);

    // 2: all-ones operands exercise the full accumulator width
    for (int e = 0; e < 16; e++) begin va[e] = 255; vb[e] = 255; end
    do_load(0, 8'hCA, va);
    do_load(0, 8'hCB, vb);
    do_op(0, 8'hBB, 0);
    do_read(0);

    // 3: sum
    for (int e = 0; e < 16; e++) begin va[e] = e + 1; vb[e] = e + 5; end
    do_load(0, 8'hCA, va);
    do_load(0, 8'hCB, vb);
    do_op(0, 8'hBC, 0);
    do_read(0);

    // 4: opcode change while busy is dropped and not replayed
    do_op(0, 8'hBB, 3);
    for (int c = 0; c < 3; c++) begin
      check("no_replay_idle", int'(busy2), 0);
      tick();
    end
    uio2 = 8'h00;
    tick();
    do_read(0);

    // 5: reset mid-MUL, READ held on uio auto-starts after release
    uio2 = 8'hBB;
    tick();
    uio2 = 8'h00;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("reset_drops_busy", int'(busy2), 0);
    uio2 = 8'hEE;
    tick();
    clear_model();
    push_expected(0);
    vcnt[0] = 0;
    rst_n = 1'b1;
    tick();
    check("auto_read_busy", int'(busy2), 1);
    uio2 = 8'h00;
    read_wait(0);

    // 6: N=3, DW=4, identity times 1..9
    for (int e = 0; e < 16; e++) begin
      va[e] = (e == 0 || e == 4 || e == 8) ? 1 : 0;
      vb[e] = e + 1;
    end
    do_load(1, 8'hCA, va);
    do_load(1, 8'hCB, vb);
    do_op(1, 8'hBB, 0);
    do_read(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
